// File: rtl/pixel_addr_decoder.sv
// pixel_addr_decoder: turns a linear frame-buffer address (x + VIDEO_WIDTH*y)
// back into (x_loc, y_loc) with a 9-step sequential restoring divider.
// Valid/ready handshakes on both sides; one address in flight at a time.
module pixel_addr_decoder #(
  parameter int VIDEO_WIDTH         = 640,
  parameter int VIDEO_HEIGHT        = 480,
  parameter int PIXEL_ADDRESS_WIDTH = 20
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PIXEL_ADDRESS_WIDTH-1:0] address,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [9:0]                     x_loc,
  output logic [8:0]                     y_loc,
  output logic                           out_of_range
);

  // One extra bit of headroom so the divisor shifted left by 8 never truncates.
  localparam int RW = PIXEL_ADDRESS_WIDTH + 1;
  localparam logic [RW-1:0] LP_DIVISOR = RW'(VIDEO_WIDTH);
  localparam logic [RW-1:0] LP_FRAME   = RW'(VIDEO_WIDTH * VIDEO_HEIGHT);
  localparam logic [3:0]    LP_K_TOP   = 4'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          r_state;
  logic [RW-1:0]   r_rem;
  logic [8:0]      r_quot;
  logic [3:0]      r_k;
  logic [9:0]      r_x;
  logic [8:0]      r_y;
  logic            r_oor;
  logic            r_out_valid;

  logic [RW-1:0]   w_div_shift;
  logic            w_ge;
  logic [RW-1:0]   w_rem_next;
  logic [8:0]      w_quot_next;
  logic            w_addr_oor;

  // One restoring step: try to subtract divisor<<k and record quotient bit k.
  always_comb begin
    w_div_shift = LP_DIVISOR << r_k;
    w_ge        = (r_rem >= w_div_shift);
    w_rem_next  = w_ge ? (r_rem - w_div_shift) : r_rem;
    w_quot_next = r_quot | (9'(w_ge) << r_k);
    w_addr_oor  = ({1'b0, address} >= LP_FRAME);
  end

  // Control FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_quot      <= '0;
      r_k         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_oor       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (w_addr_oor) begin
              // Nothing to divide: report immediately with zeroed coordinates.
              r_oor       <= 1'b1;
              r_x         <= '0;
              r_y         <= '0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_rem   <= {1'b0, address};
              r_quot  <= '0;
              r_k     <= LP_K_TOP;
              r_oor   <= 1'b0;
              r_state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          if (r_k == 4'd0) begin
            r_y         <= w_quot_next;
            r_x         <= w_rem_next[9:0];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_k <= r_k - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Accept only when idle; reset forces IDLE so this reads 1 during reset.
  assign in_ready     = (r_state == IDLE);
  assign out_valid    = r_out_valid;
  assign x_loc        = r_x;
  assign y_loc        = r_y;
  assign out_of_range = r_oor;

endmodule

// File: tb/tb_pixel_addr_decoder.sv
// Self-checking bench for pixel_addr_decoder: directed and random addresses
// compared against a plain div/mod reference model.
module tb_pixel_addr_decoder;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] address;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  x_loc;
  logic [8:0]  y_loc;
  logic        out_of_range;

  int n_cmp;
  int n_bad;

  pixel_addr_decoder #(
    .VIDEO_WIDTH(640),
    .VIDEO_HEIGHT(480),
    .PIXEL_ADDRESS_WIDTH(20)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .address(address),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_loc(x_loc),
    .y_loc(y_loc),
    .out_of_range(out_of_range)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One transaction, entered just after a negedge and left just after the
  // negedge that follows the output handshake.
  task automatic do_txn(input logic [19:0] a, input int hold, input bit poke, input bit verbose);
    int unsigned ex, ey, eo, elat;
    int n;
    eo   = (a >= 20'd307200) ? 1 : 0;
    ex   = eo ? 0 : a % 640;
    ey   = eo ? 0 : a / 640;
    elat = eo ? 0 : 9;

    address  = a;
    in_valid = 1'b1;
    check_val("in_ready_idle", in_ready, 1);
    out_ready = (hold == 0);
    @(negedge clock);
    in_valid = 1'b0;
    address  = 20'($urandom);
    n = 0;
    while (!out_valid && n < 30) begin
      if (poke) in_valid = 1'($urandom);
      check_val("in_ready_busy", in_ready, 0);
      @(negedge clock);
      n++;
    end
    check_val("latency", n, elat);
    for (int i = 0; i < hold; i++) begin
      if (poke) in_valid = 1'($urandom);
      check_val("hold_valid", out_valid, 1);
      check_val("hold_in_ready", in_ready, 0);
      check_val("hold_x", x_loc, ex);
      check_val("hold_y", y_loc, ey);
      @(negedge clock);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_val("x_loc", x_loc, ex);
    check_val("y_loc", y_loc, ey);
    check_val("out_of_range", out_of_range, eo);
    check_val("out_valid", out_valid, 1);
    if (verbose)
      $display("txn addr=%0d -> x=%0d y=%0d oor=%0d lat=%0d", a, x_loc, y_loc, out_of_range, n);
    @(negedge clock);
    out_ready = 1'b0;
    check_val("valid_drop", out_valid, 0);
    check_val("ready_rise", in_ready, 1);
    check_val("x_kept", x_loc, ex);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    address   = '0;
    repeat (3) @(negedge clock);
    check_val("rst_x", x_loc, 0);
    check_val("rst_y", y_loc, 0);
    check_val("rst_oor", out_of_range, 0);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed cases.
    do_txn(20'd64100, 0, 1'b0, 1'b1);
    do_txn(20'd0, 0, 1'b0, 1'b1);
    do_txn(20'd307199, 0, 1'b0, 1'b1);
    do_txn(20'd307200, 0, 1'b0, 1'b1);
    do_txn(20'hFFFFF, 2, 1'b0, 1'b1);
    do_txn(20'd640, 5, 1'b1, 1'b1);

    // Random addresses across the full 20-bit space, random back-pressure.
    for (int i = 0; i < 40; i++)
      do_txn(20'($urandom), $urandom_range(0, 3), 1'b1, 1'b1);
    for (int i = 0; i < 40; i++)
      do_txn(20'($urandom_range(0, 307199)), $urandom_range(0, 2), 1'b0, 1'b1);

    // Row sweeps.
    for (int r = 0; r < 4; r++) begin
      int yy;
      yy = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 239 : 479;
      for (int xx = 0; xx < 640; xx++)
        do_txn(20'(xx + 640 * yy), 0, 1'b0, 1'b0);
      $display("txn sweep row y=%0d done", yy);
    end

    // Reset in the middle of a division (previous result was 639,479).
    address  = 20'd64100;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #2;
    check_val("mid_rst_x", x_loc, 0);
    check_val("mid_rst_y", y_loc, 0);
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_in_ready", in_ready, 1);
    $display("txn reset mid-divide -> x=%0d y=%0d valid=%0d", x_loc, y_loc, out_valid);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_val("post_rst_valid", out_valid, 0);
    do_txn(20'd1279, 1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_addr_decoder.md
# pixel_addr_decoder

Converts a linear frame-buffer pixel address (address = x + 640*y, as produced by the boid processing unit on the write side) back into screen coordinates (x_loc, y_loc). Sits on the read/inspection side of the frame buffer, e.g. for collision lookup or debug readback. Uses a 9-step sequential restoring divider by VIDEO_WIDTH, with valid/ready handshakes on both input and output.

## Interface
- VIDEO_WIDTH, 640: pixels per line; the divisor.
- VIDEO_HEIGHT, 480: lines per frame.
- PIXEL_ADDRESS_WIDTH, 20: address width, $clog2(VIDEO_WIDTH*VIDEO_HEIGHT)+1.
- clock  in  1  50 MHz system clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  address is presented.
- in_ready  out  1  block accepts an address; high only in IDLE.
- address  in  PIXEL_ADDRESS_WIDTH  linear pixel address.
- out_valid  out  1  result is valid; high only in DONE.
- out_ready  in  1  consumer takes the result.
- x_loc  out  10  column, 0..639.
- y_loc  out  9  row, 0..479.
- out_of_range  out  1  the accepted address was >= VIDEO_WIDTH*VIDEO_HEIGHT.

## Operation
- States: IDLE, DIVIDE, DONE. Reset state is IDLE.
- Reset values: x_loc=0, y_loc=0, out_of_range=0, out_valid=0, step counter=0, remainder=0. in_ready reads 1 while in reset, but no transfer occurs while reset_n is low.
- Input handshake: a transfer occurs on an edge where in_valid && in_ready. address is sampled on that edge only.
- IDLE with transfer, address >= 307200: go to DONE. Set out_of_range=1, x_loc=0, y_loc=0.
- IDLE with transfer, address < 307200: go to DIVIDE. Load remainder=address, quotient=0, k=8. Clear out_of_range.
- DIVIDE, one edge per k, for k=8 down to 0:
  - If remainder >= (640<<k): remainder -= 640<<k and quotient bit k = 1.
  - Otherwise quotient bit k = 0.
  - The comparison is done at PIXEL_ADDRESS_WIDTH+1 bits so the shifted divisor never truncates.
- After the k=0 edge: y_loc=quotient[8:0], x_loc=remainder[9:0]. Go to DONE.
- DONE: out_valid=1. x_loc, y_loc and out_of_range stay stable until out_valid && out_ready, then go to IDLE. Outputs keep their last values in IDLE.
- In DIVIDE and DONE, in_ready=0. in_valid is ignored and there is no input skid buffer.
- Arithmetic: the input range guarantees the quotient is at most 479 (9 bits) and the remainder is at most 639 (10 bits). No overflow is possible in range.

## Timing
- Call the accepting edge T.
- In-range latency: the iterations occur on edges T+1..T+9. out_valid is high after edge T+9, i.e. 9 cycles after acceptance.
- Out-of-range latency: out_valid is high immediately after edge T.
- Output handshake on edge U: out_valid drops after U and in_ready rises after U. The next address can be accepted no earlier than edge U+1.
- Minimum in-range throughput is one result per 11 cycles (accept, 9 steps, output handshake).
- out_ready may already be high when DONE is entered. The handshake then completes on the first edge in DONE.
- Reset asserted mid-DIVIDE or in DONE: the block returns to IDLE at once with all outputs at their reset values. The in-flight result is discarded.

## Test plan
- address=64100 (x=100, y=100), out_ready=1 -> out_valid high 9 cycles after acceptance; x_loc=100, y_loc=100, out_of_range=0.
- address=0, then 307199, back to back -> (0,0), then (639,479). The second transfer is accepted exactly 1 cycle after the first output handshake.
- address=307200, then 0xFFFFF -> each gives out_of_range=1, x_loc=0, y_loc=0, with out_valid high the cycle after acceptance.
- address=640 with out_ready held low for 5 cycles in DONE; in_valid pulsed during DIVIDE and DONE -> x_loc=0, y_loc=1 held stable throughout; in_ready stays 0 and no extra transfer occurs.
- Sweep of all x in 0..639 at y=0, 1, 239 and 479 -> every result matches the reference model address = x + 640*y.
- reset_n pulsed low at DIVIDE step 4 -> outputs are 0 and state is IDLE; a fresh address=1279 then yields x_loc=639, y_loc=1.
